// File: rtl/tl_b_pkg.sv
// Shared TileLink B-channel types, opcodes and beat helpers.
package tl_b_pkg;

   localparam logic [2:0] OP_PUT_FULL    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] OP_ARITHMETIC  = 3'd2;
   localparam logic [2:0] OP_LOGICAL     = 3'd3;
   localparam logic [2:0] OP_GET         = 3'd4;
   localparam logic [2:0] OP_INTENT      = 3'd5;
   localparam logic [2:0] OP_PROBE       = 3'd6;

   // log2 of the largest message we split into beats (64 bytes = 8 beats of 8 bytes)
   localparam logic [3:0] MAX_SIZE  = 4'd6;
   localparam logic [3:0] BEAT_LOG2 = 4'd3;

   typedef struct packed {
      logic [2:0]  opcode;
      logic [1:0]  param;
      logic [3:0]  size;
      logic [31:0] address;
      logic [7:0]  mask;
      logic [63:0] data;
      logic        corrupt;
   } tl_b_msg_t;

   // Put/Atomic messages carry data beats; Get/Intent/Probe are header only.
   function automatic logic has_data(input logic [2:0] opcode);
      return opcode <= OP_LOGICAL;
   endfunction

   // Beat count of a message; oversize requests are clamped to 8 beats.
   function automatic logic [3:0] num_beats(input logic [3:0] size, input logic data);
      logic [3:0] capped;
      capped = (size > MAX_SIZE) ? MAX_SIZE : size;
      if (!data || capped <= BEAT_LOG2) begin
         return 4'd1;
      end
      return 4'd1 << (capped - BEAT_LOG2);
   endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick with a lock override, shared by channel arbiters.
module rr_arbiter_core #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] rr_ptr,
   input  logic          lock,
   input  logic [IW-1:0] lock_idx,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] winner
);

   logic          found;
   logic [IW-1:0] idx;

   // Scan rr_ptr+1, rr_ptr+2, ... and take the first requester; a lock pins the choice.
   always_comb begin
      winner = '0;
      grant  = '0;
      found  = 1'b0;
      idx    = '0;
      if (lock) begin
         winner = lock_idx;
      end else begin
         for (int unsigned k = 1; k <= N; k++) begin
            idx = IW'((32'(rr_ptr) + k) % N);
            if (!found && req[idx]) begin
               found  = 1'b1;
               winner = idx;
            end
         end
      end
      if (req[winner]) begin
         grant[winner] = 1'b1;
      end
   end

endmodule

// File: rtl/tl_b_channel_arbiter.sv
// Shares one hart's TileLink B channel between NUM_REQ requesters with round-robin
// priority, multi-beat locking and per-requester outstanding-Probe tracking.
module tl_b_channel_arbiter
   import tl_b_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned BEAT_BYTES = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*3-1:0]         req_opcode,
   input  logic [NUM_REQ*2-1:0]         req_param,
   input  logic [NUM_REQ*4-1:0]         req_size,
   input  logic [NUM_REQ*32-1:0]        req_address,
   input  logic [NUM_REQ*BEAT_BYTES-1:0]   req_mask,
   input  logic [NUM_REQ*BEAT_BYTES*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]           req_corrupt,
   output logic                         b_valid,
   input  logic                         b_ready,
   output logic [2:0]                   b_opcode,
   output logic [1:0]                   b_param,
   output logic [3:0]                   b_size,
   output logic [2:0]                   b_source,
   output logic [31:0]                  b_address,
   output logic [BEAT_BYTES-1:0]        b_mask,
   output logic [BEAT_BYTES*8-1:0]      b_data,
   output logic                         b_corrupt,
   input  logic                         ack_valid,
   input  logic [2:0]                   ack_source,
   output logic [NUM_REQ-1:0]           probe_busy
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned DW = BEAT_BYTES * 8;

   tl_b_msg_t          msg [NUM_REQ];
   tl_b_msg_t          sel;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      winner;
   logic               fire;
   logic [3:0]         beats;
   logic               ack_in_range;

   logic               lock_q, lock_d;
   logic [IW-1:0]      lock_idx_q, lock_idx_d;
   logic [2:0]         beat_cnt_q, beat_cnt_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] probe_busy_q, probe_busy_d;

   // Unpack per-requester payloads; a Probe is held back while its requester has one in flight.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         msg[i].opcode  = req_opcode[i*3 +: 3];
         msg[i].param   = req_param[i*2 +: 2];
         msg[i].size    = req_size[i*4 +: 4];
         msg[i].address = req_address[i*32 +: 32];
         msg[i].mask    = req_mask[i*BEAT_BYTES +: BEAT_BYTES];
         msg[i].data    = req_data[i*DW +: DW];
         msg[i].corrupt = req_corrupt[i];
         eligible[i]    = req_valid[i] && !(msg[i].opcode == OP_PROBE && probe_busy_q[i]);
      end
   end

   rr_arbiter_core #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_core (
      .req      (eligible),
      .rr_ptr   (rr_ptr_q),
      .lock     (lock_q),
      .lock_idx (lock_idx_q),
      .grant    (grant),
      .winner   (winner)
   );

   // Zero-latency payload mux and handshake outputs.
   always_comb begin
      sel       = msg[winner];
      b_valid   = |eligible;
      b_opcode  = sel.opcode;
      b_param   = sel.param;
      b_size    = sel.size;
      b_source  = 3'(winner);
      b_address = sel.address;
      b_mask    = sel.mask;
      b_data    = sel.data;
      b_corrupt = sel.corrupt;
      req_ready = b_ready ? grant : '0;
      fire      = b_valid && b_ready;
      beats     = num_beats(sel.size, has_data(sel.opcode));
   end

   assign ack_in_range = ({1'b0, ack_source} < 4'(NUM_REQ));
   assign probe_busy   = probe_busy_q;

   // Lock/beat/pointer bookkeeping and Probe tracking (a set beats a same-cycle clear).
   always_comb begin
      lock_d       = lock_q;
      lock_idx_d   = lock_idx_q;
      beat_cnt_d   = beat_cnt_q;
      rr_ptr_d     = rr_ptr_q;
      probe_busy_d = probe_busy_q;

      if (fire) begin
         if (beat_cnt_q == 3'd0) begin
            if (beats > 4'd1) begin
               lock_d     = 1'b1;
               lock_idx_d = winner;
               beat_cnt_d = 3'(beats - 4'd1);
            end else begin
               lock_d   = 1'b0;
               rr_ptr_d = winner;
            end
         end else begin
            beat_cnt_d = beat_cnt_q - 3'd1;
            if (beat_cnt_q == 3'd1) begin
               lock_d   = 1'b0;
               rr_ptr_d = winner;
            end
         end
      end else if (b_valid) begin
         // Backpressured: pin the current winner until its message completes.
         lock_d     = 1'b1;
         lock_idx_d = winner;
      end

      if (ack_valid && ack_in_range) begin
         probe_busy_d[ack_source[IW-1:0]] = 1'b0;
      end
      if (fire && sel.opcode == OP_PROBE) begin
         probe_busy_d[winner] = 1'b1;
      end
   end

   // State registers with synchronous reset; requester 0 wins first after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         lock_q       <= 1'b0;
         lock_idx_q   <= '0;
         beat_cnt_q   <= 3'd0;
         rr_ptr_q     <= IW'(NUM_REQ - 1);
         probe_busy_q <= '0;
      end else begin
         lock_q       <= lock_d;
         lock_idx_q   <= lock_idx_d;
         beat_cnt_q   <= beat_cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         probe_busy_q <= probe_busy_d;
      end
   end

endmodule

// File: doc/tl_b_channel_arbiter.md
Name: tl_b_channel_arbiter

Overview:
- Round-robin arbiter that shares one hart's TileLink B channel (Probe/Get/Put forwarding) between up to 8 requesters, e.g. L2 banks or the debug/coherence agent.
- Locks multi-beat data messages, assigns B-channel source IDs by requester index, and tracks outstanding Probes until the matching ProbeAck is reported.
- Sits between the coherence managers and the hart's B-channel port, at the same boundary as the hart B-channel trace interface.

Parameters:
- NUM_REQ, 4, number of requesters, 2..8; requester i always drives b_source = i.
- BEAT_BYTES, 8, data bytes per beat; fixed by the 64-bit data width.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester message valid
- req_ready  out  NUM_REQ  per-requester accept
- req_opcode  in  NUM_REQ*3  packed per requester
- req_param  in  NUM_REQ*2
- req_size  in  NUM_REQ*4  log2 bytes
- req_address  in  NUM_REQ*32
- req_mask  in  NUM_REQ*8
- req_data  in  NUM_REQ*64
- req_corrupt  in  NUM_REQ
- b_valid  out  1
- b_ready  in  1
- b_opcode  out  3
- b_param  out  2
- b_size  out  4
- b_source  out  3  winner index, zero-extended
- b_address  out  32
- b_mask  out  8
- b_data  out  64
- b_corrupt  out  1
- ack_valid  in  1  ProbeAck/ProbeAckData first beat fired on the C channel
- ack_source  in  3  source of that ack
- probe_busy  out  NUM_REQ  requester has a Probe outstanding

Behaviour:
- Reset: b_valid=0, req_ready=0, probe_busy=0, lock=0, beat_cnt=0, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- Eligibility: eligible[i] = req_valid[i] && !(req_opcode[i]==Probe(6) && probe_busy[i]). Non-Probe opcodes are never blocked.
- Selection: zero-latency combinational path. When unlocked, the winner is the first eligible index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
- b_* = winner's payload muxed combinationally; b_valid = |eligible.
- req_ready[i] = b_ready && (winner==i); all other ready bits are 0.
- Fire = b_valid && b_ready.
- Hold rule: if b_valid=1 and b_ready=0, set lock=1 and latch winner into lock_idx. Selection stays at lock_idx until the message's last beat fires. This holds even if a higher-priority requester becomes valid. Requesters keep their payload stable per TileLink rules; the arbiter does not check this.
- Beats: data opcodes are 0..3 (PutFull, PutPartial, Arithmetic, Logical). beats = (size>3) ? 1<<(size-3) : 1. All other opcodes are 1 beat. size is capped at 6 (8 beats); larger sizes are treated as 6.
- First-beat fire with beats>1: lock=1, beat_cnt=beats-1. Each later fire decrements beat_cnt. The fire with beat_cnt==1 is the last beat.
- Last-beat fire (or single-beat fire): lock=0, rr_ptr=winner.
- Probe tracking: a fire with opcode Probe sets probe_busy[winner] on the next edge. ack_valid clears probe_busy[ack_source] on the next edge.
- A set and a clear of the same bit cannot coincide (set requires busy=0). If they do occur (protocol error), set wins.
- ack_source >= NUM_REQ is ignored.
- Combinational path ack_valid -> req_ready is forbidden. Eligibility uses only registered probe_busy, so a requester acked in cycle t is eligible at t+1.
- Reset mid-message: lock, beat_cnt, probe_busy and rr_ptr all return to reset values. Upstream is reset together with this block.
- No bubbles: back-to-back fires from different requesters on consecutive cycles are allowed.

Decomposition:
- Shared package tl_b_pkg:
  - TL B opcode constants: PutFull=0, PutPartial=1, Arithmetic=2, Logical=3, Get=4, Intent=5, Probe=6.
  - tl_b_msg_t struct: opcode, param, size, address, mask, data, corrupt.
  - Function has_data(opcode).
  - Function num_beats(size, has_data).
- Sub-module rr_arbiter_core: NUM_REQ-wide request vector, rr_ptr and lock/lock_idx in, one-hot grant and winner index out. Purely combinational; reused by other channel arbiters.

Test Plan:
- Three-way contention: reqs 0,1,2 all valid with single-beat Get, b_ready=1 -> grants in order 0,1,2 on consecutive cycles; b_source=0,1,2; then rr_ptr=2.
- Multi-beat lock: req1 sends PutFull size=5 (4 beats) while req0 is valid throughout -> b_source=1 for 4 consecutive fires, then req0 is granted on the 5th cycle.
- Hold under backpressure: req2 valid, b_ready=0 for 3 cycles, req0 becomes valid in cycle 1 -> b_source stays 2 with a stable payload; with b_ready=1 req2 fires, and req0 fires next cycle.
- Probe blocking: req3 Probe fires -> probe_busy[3]=1. A second req3 Probe is not granted while req0 Gets proceed. ack_valid with ack_source=3 at cycle t -> busy cleared at t+1, and the req3 Probe fires at t+1 at the earliest.
- Out-of-range ack: ack_source=7 with NUM_REQ=4 -> no probe_busy bit changes.
- Reset mid-message: reset asserted after beat 2 of an 8-beat PutFull (size=6) -> next cycle b_valid follows eligibility, lock=0, probe_busy=0, and requester 0 has first priority.
